// File: rtl/dla_rng_stream.sv
// dla_rng_stream: Galois LFSR random-sample source with a valid/ready output port.
// Optional build macro DLA_RNG_RANGE_EN rejects completed samples >= limit (limit != 0).
module dla_rng_stream #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAP   = WIDTH'('hD008),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'('hFFFF),
    parameter int               OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_value,
    input  logic [OUT_W-1:0] limit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [WIDTH-1:0] lfsr_state
);
    localparam int               CNT_W   = (OUT_W > 2) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(OUT_W - 1);
    localparam logic [WIDTH-1:0] FB_MASK = TAP & ~WIDTH'(1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [OUT_W-1:0] coll_q, coll_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic             msb;
    logic [WIDTH-1:0] lfsr_step;
    logic [OUT_W-1:0] sample;
    logic             accept_ok;

`ifndef DLA_RNG_RANGE_EN
    logic unused_limit;
    assign unused_limit = ^limit;
`endif

    always_comb begin
        msb       = lfsr_q[WIDTH-1];
        lfsr_step = {lfsr_q[WIDTH-2:0], msb} ^ (msb ? FB_MASK : '0);
        sample    = {coll_q[OUT_W-2:0], msb};
        accept_ok = 1'b1;
`ifdef DLA_RNG_RANGE_EN
        accept_ok = (limit == '0) || (sample < limit);
`endif
        state_d = state_q;
        lfsr_d  = lfsr_q;
        coll_d  = coll_q;
        count_d = count_q;
        data_d  = data_q;
        valid_d = valid_q;

        // Reseed overrides everything, including a same-cycle handshake.
        if (seed_load) begin
            lfsr_d  = (seed_value == '0) ? SEED : seed_value;
            coll_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
            state_d = FILL;
        end else if (state_q == FILL) begin
            if (lfsr_q == '0) begin
                lfsr_d = SEED;
            end else begin
                lfsr_d = lfsr_step;
                coll_d = sample;
                if (count_q == LAST) begin
                    count_d = '0;
                    if (accept_ok) begin
                        data_d  = sample;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end else begin
            if (lfsr_q == '0) begin
                lfsr_d = SEED;
            end
            if (valid_q && out_ready) begin
                valid_d = 1'b0;
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            lfsr_q  <= SEED;
            coll_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            coll_q  <= coll_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_dla_rng_stream.sv
// Bench for dla_rng_stream: directed scenarios plus a randomized run against a sample-level model.
module tb_dla_rng_stream;
    localparam int          WIDTH = 16;
    localparam logic [15:0] TAP   = 16'hD008;
    localparam logic [15:0] SEED  = 16'hFFFF;
    localparam int          OUT_W = 4;
`ifdef DLA_RNG_RANGE_EN
    localparam bit RANGE = 1'b1;
`else
    localparam bit RANGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_load;
    logic [15:0] seed_value;
    logic [3:0]  limit;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [15:0] lfsr_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dla_rng_stream #(
        .WIDTH(WIDTH), .TAP(TAP), .SEED(SEED), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_value(seed_value),
        .limit(limit), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .lfsr_state(lfsr_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One LFSR step written arithmetically: double, bring msb round to bit 0, apply taps.
    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [16:0] wide;
        wide = {1'b0, s} * 17'd2 + {16'd0, s[15]};
        return wide[15:0] ^ (s[15] ? (TAP & 16'hFFFE) : 16'h0000);
    endfunction

    task automatic m_sample(input logic [15:0] s, output logic [3:0] d, output logic [15:0] so);
        int acc;
        acc = 0;
        so  = s;
        for (int k = 0; k < OUT_W; k++) begin
            acc = acc * 2 + int'(so[15]);
            so  = m_step(so);
        end
        d = 4'(acc);
    endtask

    task automatic m_next(input logic [15:0] s, input logic [3:0] lim,
                          output logic [3:0] d, output logic [15:0] so);
        logic [15:0] cur;
        cur = s;
        d   = 4'h0;
        so  = s;
        for (int k = 0; k < 1000; k++) begin
            m_sample(cur, d, so);
            cur = so;
            if (lim == 4'h0 || d < lim) break;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0]  ed, ed2, exp_d, p_data, eff_lim;
    logic [15:0] es, es2, exp_s, p_seed;
    logic        p_valid, p_ready, p_load;
    int          wait_cnt;

    initial begin
        rst_n = 1'b0; seed_load = 1'b0; seed_value = 16'h0; limit = 4'h0; out_ready = 1'b1;
        #12;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_lfsr", 32'(lfsr_state), 32'(SEED));
        @(negedge clk);
        rst_n = 1'b1;
        m_sample(SEED, ed, es);
        tick(3);
        chk("early_valid", 32'(out_valid), 32'd0);
        tick(1);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_data", 32'(out_data), 32'(ed));
        chk("first_data_lit", 32'(out_data), 32'h9);
        chk("first_lfsr", 32'(lfsr_state), 32'(es));
        chk("first_lfsr_lit", 32'(lfsr_state), 32'hAFB1);
        tick(1);
        chk("drop_valid", 32'(out_valid), 32'd0);

        // Back-pressure: sample must hold still
        out_ready = 1'b0;
        do_reset();
        tick(4);
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'(ed));
            chk("bp_hold_lfsr", 32'(lfsr_state), 32'(es));
        end
        @(negedge clk);
        out_ready = 1'b1;
        tick(1);
        chk("bp_accept", 32'(out_valid), 32'd0);
        m_sample(es, ed2, es2);
        tick(3);
        chk("bp_fill", 32'(out_valid), 32'd0);
        tick(1);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_data", 32'(out_data), 32'(ed2));
        chk("bp_next_lfsr", 32'(lfsr_state), 32'(es2));

        // Reseed with zero while holding, ready high in the same cycle
        @(negedge clk);
        seed_load = 1'b1; seed_value = 16'h0; out_ready = 1'b1;
        tick(1);
        chk("sl_valid", 32'(out_valid), 32'd0);
        chk("sl_lfsr", 32'(lfsr_state), 32'(SEED));
        @(negedge clk);
        seed_load = 1'b0;
        tick(3);
        chk("sl_fill", 32'(out_valid), 32'd0);
        tick(1);
        chk("sl_valid2", 32'(out_valid), 32'd1);
        chk("sl_data", 32'(out_data), 32'h9);

        // Lock-up recovery mid-fill
        tick(3);
        @(negedge clk);
        force dut.lfsr_q = 16'h0;
        #1;
        release dut.lfsr_q;
        chk("lk_zero", 32'(lfsr_state), 32'd0);
        @(posedge clk);
        #1;
        chk("lk_lfsr", 32'(lfsr_state), 32'(SEED));
        chk("lk_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-fill with a previous sample still on out_data
        do_reset();
        tick(4);
        chk("ar_first", 32'(out_valid), 32'd1);
        tick(3);
        chk("ar_mid_data", 32'(out_data), 32'h9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_data", 32'(out_data), 32'd0);
        chk("ar_lfsr", 32'(lfsr_state), 32'(SEED));
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        chk("ar_again_valid", 32'(out_valid), 32'd1);
        chk("ar_again_data", 32'(out_data), 32'h9);

        // Randomized run: random ready, occasional reseeds, model tracks the sample stream
`ifdef DLA_RNG_RANGE_EN
        limit = 4'h8;
`else
        limit = 4'($urandom);
`endif
        eff_lim = RANGE ? limit : 4'h0;
        seed_load = 1'b0;
        do_reset();
        m_next(SEED, eff_lim, exp_d, exp_s);
        wait_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            out_ready  = ($urandom_range(0, 3) != 0);
            seed_load  = ($urandom_range(0, 59) == 0);
            seed_value = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            p_valid = out_valid;
            p_data  = out_data;
            p_ready = out_ready;
            p_load  = seed_load;
            p_seed  = (seed_value == 16'h0) ? SEED : seed_value;
            @(posedge clk);
            #1;
            if (p_load) begin
                chk("r_load_valid", 32'(out_valid), 32'd0);
                chk("r_load_lfsr", 32'(lfsr_state), 32'(p_seed));
                m_next(p_seed, eff_lim, exp_d, exp_s);
                wait_cnt = 0;
            end else if (p_valid && p_ready) begin
                chk("r_accept", 32'(out_valid), 32'd0);
                wait_cnt = 0;
            end else if (p_valid) begin
                chk("r_hold_valid", 32'(out_valid), 32'd1);
                chk("r_hold_data", 32'(out_data), 32'(p_data));
            end else if (out_valid) begin
                chk("r_data", 32'(out_data), 32'(exp_d));
                chk("r_lfsr", 32'(lfsr_state), 32'(exp_s));
                if (RANGE) chk("r_below_limit", 32'(out_data < limit), 32'd1);
                m_next(exp_s, eff_lim, exp_d, exp_s);
            end else begin
                wait_cnt++;
                if (wait_cnt > 400) begin
                    chk("r_timeout", 32'(wait_cnt), 32'd0);
                    wait_cnt = 0;
                end
            end
        end
        seed_load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dla_rng_stream.md
Name: dla_rng_stream

Overview:
- Parametrised Galois LFSR random-number source for the diffusion-limited-aggregation engine.
- Shifts a WIDTH-bit LFSR one step per cycle and collects the MSB of each step into an OUT_W-bit sample.
- Presents each sample on a valid/ready output port. Supports runtime reseeding and all-zero lock-up recovery.
- Feeds the random-walk step/direction logic and the particle spawn-position logic.

Parameters:
WIDTH, 16, LFSR state width (>=4)
TAP, 'hD008, feedback mask; bit i set => XOR feedback into state bit i (i>=1); TAP[0] ignored
SEED, 'hFFFF, reset/default seed; must be non-zero
OUT_W, 4, bits per output sample (2..WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
seed_load  in  1  load seed_value into LFSR (single-cycle pulse)
seed_value  in  WIDTH  runtime seed; zero means use SEED
limit  in  OUT_W  exclusive upper bound for samples (DLA_RNG_RANGE_EN only; ignored otherwise)
out_valid  out  1  sample available
out_ready  in  1  consumer accepts sample
out_data  out  OUT_W  random sample
lfsr_state  out  WIDTH  current LFSR register (debug)

Behaviour:
- Reset (async assert, sync release):
  - lfsr=SEED, collector=0, count=0, state=FILL.
  - out_valid=0, out_data=0.
- LFSR step (msb = lfsr[WIDTH-1]):
  - next[0] = msb.
  - next[i] = lfsr[i-1] ^ (TAP[i] & msb) for i>=1.
- FSM states: FILL, HOLD.
- FILL, each cycle:
  - LFSR steps.
  - collector <= {collector[OUT_W-2:0], msb}, using the pre-step msb.
  - count++.
  - When count reaches OUT_W-1 on a step: out_data <= completed collector, out_valid <= 1, count <= 0, state -> HOLD.
- Latency: out_valid rises at the edge that completes the OUT_W-th step, i.e. OUT_W cycles after reset release. The first-collected bit lands in out_data[OUT_W-1].
- HOLD:
  - LFSR, collector and out_data frozen.
  - On out_valid&&out_ready: out_valid <= 0, state -> FILL.
  - Sample period with out_ready held high: OUT_W+1 cycles.
- Handshake rules:
  - out_data stable while out_valid=1 and not accepted.
  - out_valid never drops without acceptance, except on seed_load or reset.
- seed_load (priority over all FSM activity):
  - lfsr <= (seed_value==0 ? SEED : seed_value).
  - collector=0, count=0, out_valid=0, state=FILL.
  - Any pending sample is discarded, even if out_ready is high in the same cycle; no handshake is counted.
- Lock-up guard: if lfsr==0 in any cycle (e.g. SEU), the next edge loads SEED instead of stepping; count and collector unchanged.
- Reset mid-fill or mid-hold: returns immediately to reset values; no partial sample is ever emitted.

Optional Feature:
- Macro: DLA_RNG_RANGE_EN.
- Enabled, at sample completion:
  - If limit!=0 and collector>=limit (unsigned), the sample is rejected: out_valid stays 0, count=0, FILL continues and the LFSR keeps stepping.
  - limit is sampled at completion time; limit==0 means no bound.
- Disabled: limit is ignored and every completed sample is presented.

Test Plan:
- WIDTH=16, TAP='hD008, SEED='hFFFF, OUT_W=4, out_ready=1; release rst_n -> after 4 clocks out_valid=1, out_data=4'h9, lfsr_state=16'hAFB1; valid drops the next cycle.
- Same setup, out_ready=0 for 10 cycles after valid -> out_data stays 4'h9, lfsr_state stays 16'hAFB1, out_valid stays 1; raise ready -> one accept, then the next sample 5 cycles later.
- Pulse seed_load with seed_value=0 while in HOLD -> out_valid=0 next cycle, lfsr_state=16'hFFFF, next sample out_data=4'h9 again after 4 cycles.
- Force lfsr to 0 via seed path bypass/force -> next edge lfsr_state=16'hFFFF, no out_valid glitch.
- DLA_RNG_RANGE_EN, limit=4'h8 -> first sample (9) rejected and never presented; every presented out_data <8 over 1000 samples; limit=0 -> first out_data=9.
- Assert rst_n=0 asynchronously mid-FILL (count=2) -> out_valid and out_data 0 without a clock edge; after release, first sample again 4'h9 after 4 clocks.
